controlador_alu: RTL and testbench
==================================

# controlador_alu

Sequencing controller for the lab ALU datapath: accepts an operand pair and opcode through a start/ready handshake and registers the operands toward the functional units. It drives the 4-bit opcode onto the result multiplexer's select input and waits the operation's latency. It then captures the multiplexer output with zero/negative flags and presents it with a one-cycle valid pulse. It sits between the switch/button input logic and the ALU result multiplexer, on the driving side of the select bus.

## Interface

**Parameters**

- `ancho`, default 3: MSB index of operands and result; data width is `ancho+1`.
- `latenciaDiv`, default 4: cycles spent in EJECUTA for division and modulo; must be ≥1.

**Ports**

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inicio`  in  1  request valid.
- `listo`  out  1  ready; high only in ESPERA.
- `operandoA`  in  ancho+1  operand A.
- `operandoB`  in  ancho+1  operand B.
- `operacion`  in  4  opcode 0..9: suma, resta, multiplicación, división, módulo, AND, OR, XOR, shift left, shift right.
- `seleccion`  out  4  registered select to the result multiplexer.
- `salidaA`, `salidaB`  out  ancho+1  registered operands to the functional units.
- `resultadoMux`  in  ancho+1  result multiplexer output.
- `resultado`  out  ancho+1  captured result.
- `cero`, `negativo`  out  1  flags of the captured result.
- `error`  out  1  request rejected; qualified by `valido`.
- `valido`  out  1  one-cycle result strobe.

## Operation

- States: ESPERA, EJECUTA, ENTREGA.
- **ESPERA:** `listo`=1. A request is accepted when `inicio`=1 at the clock edge.
- **Invalid request:** opcode 10..15, or opcode 3 or 4 with `operandoB`=0.
  - Go to ENTREGA with `error`=1, `resultado`=0, `cero`=0, `negativo`=0.
  - `seleccion`, `salidaA` and `salidaB` are unchanged.
- **Valid request:**
  - Load `seleccion`←`operacion`, `salidaA`←`operandoA`, `salidaB`←`operandoB`, `error`←0.
  - Load the counter with L−1, where L=`latenciaDiv` for opcodes 3/4 and L=1 otherwise.
  - Go to EJECUTA.
- **EJECUTA:**
  - Counter≠0: decrement.
  - Counter=0: capture `resultado`←`resultadoMux`, `cero`←(`resultadoMux`==0), `negativo`←`resultadoMux[ancho]`, then go to ENTREGA.
- **ENTREGA:** `valido`=1 for exactly one cycle, then go to ESPERA.
- `inicio` outside ESPERA is ignored; requests are not queued.
- `resultado`, flags, `seleccion` and `salidaA/B` hold their values until the next capture or load.
- Arithmetic is performed by the external units; this block does no arithmetic beyond the counter and the zero compare.

## Timing

- **Reset values:** state ESPERA, `listo`=1, `valido`=0, `error`=0, `cero`=0, `negativo`=0; `seleccion`, `salidaA`, `salidaB`, `resultado` all 0.
- **Valid request accepted at edge k:** EJECUTA covers cycles k..k+L−1. Capture happens at edge k+L. `valido` is high from k+L to k+L+1. `listo` rises at k+L+1.
- **Invalid request accepted at edge k:** `valido` and `error` are high from k to k+1. `listo` rises at k+1.
- **Throughput:** one request per L+2 cycles (valid) or per 2 cycles (rejected).
- `resultadoMux` must be stable during the final EJECUTA cycle; it is sampled only at the capture edge.
- **Reset mid-operation:** immediately returns to ESPERA with reset values. No `valido` pulse is produced for the aborted request.

## Structure

- Shared package `alu_pkg`:
  - opcode constants `OP_SUMA`=0 … `OP_SHIFT_DER`=9;
  - state enum {ESPERA, EJECUTA, ENTREGA};
  - helper function `esValida(operacion, operandoB)`.
- The result multiplexer imports the same opcode constants.
- One sub-module: `contador_latencia`, a loadable down-counter with a zero flag, width `$clog2(latenciaDiv)`+1.

## Test plan

All scenarios use `ancho`=3 and `latenciaDiv`=4; the bench models the ALU.

1. **Reset:** assert `rst` for 2 cycles → `listo`=1, `valido`=0, `resultado`=0, `seleccion`=0.
2. **Suma:** A=3, B=5, op 0 accepted at edge k → `seleccion`=0 from k; `valido` at k+1..k+2 with `resultado`=8, `negativo`=1, `cero`=0, `error`=0; `listo` rises at k+2.
3. **División:** A=9, B=2, op 3, with `inicio` held high throughout → `seleccion`=3 for 4 cycles; `valido` at k+4 with `resultado`=4; exactly one result is produced.
4. **Rejections:**
   - A=7, B=0, op 4 → `valido`=`error`=1 at k..k+1, `resultado`=0, `seleccion` unchanged.
   - op 12 → same response.
5. **XOR to zero:** A=6, B=6, op 7 → `resultado`=0, `cero`=1.
6. **Reset mid-operation:** assert `rst` during division at k+2 → `listo`=1 at once, no `valido` pulse; a following suma 1+1 returns 2 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU: opcode numbering, controller states and
// the request validity rule used by the sequencing controller.
package alu_pkg;

  localparam logic [3:0] OP_SUMA       = 4'd0;
  localparam logic [3:0] OP_RESTA      = 4'd1;
  localparam logic [3:0] OP_MULT       = 4'd2;
  localparam logic [3:0] OP_DIV        = 4'd3;
  localparam logic [3:0] OP_MOD        = 4'd4;
  localparam logic [3:0] OP_AND        = 4'd5;
  localparam logic [3:0] OP_OR         = 4'd6;
  localparam logic [3:0] OP_XOR        = 4'd7;
  localparam logic [3:0] OP_SHIFT_IZQ  = 4'd8;
  localparam logic [3:0] OP_SHIFT_DER  = 4'd9;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    EJECUTA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  // operandoB arrives zero-extended so the rule is independent of data width.
  function automatic logic esValida(input logic [3:0] operacion, input logic [31:0] operandoB);
    logic divide;
    divide = (operacion == OP_DIV) || (operacion == OP_MOD);
    return (operacion <= OP_SHIFT_DER) && !(divide && (operandoB == 32'd0));
  endfunction

endpackage

// File: rtl/controlador_alu_if.sv
// Bus between the input logic, the ALU controller and the result multiplexer.
interface controlador_alu_if #(parameter int ancho = 3);
  import alu_pkg::*;

  // Handshake: a request transfers on a rising edge where inicio and listo are
  // both high; listo drops for the whole operation and valido pulses for one
  // cycle when resultado/cero/negativo/error are meaningful.
  logic             inicio;
  logic             listo;
  logic [ancho:0]   operandoA;
  logic [ancho:0]   operandoB;
  logic [3:0]       operacion;
  logic [3:0]       seleccion;
  logic [ancho:0]   salidaA;
  logic [ancho:0]   salidaB;
  logic [ancho:0]   resultadoMux;
  logic [ancho:0]   resultado;
  logic             cero;
  logic             negativo;
  logic             error;
  logic             valido;
  estado_t          estado;

  modport master (
    output inicio, operandoA, operandoB, operacion, resultadoMux,
    input  listo, seleccion, salidaA, salidaB, resultado, cero, negativo,
           error, valido, estado
  );

  modport slave (
    input  inicio, operandoA, operandoB, operacion, resultadoMux,
    output listo, seleccion, salidaA, salidaB, resultado, cero, negativo,
           error, valido, estado
  );

endinterface

// File: rtl/contador_latencia.sv
// Loadable down-counter that times the EJECUTA phase; esCero marks the capture cycle.
module contador_latencia #(
    parameter int anchoCnt = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cargar,
    input  logic [anchoCnt-1:0] valor,
    input  logic                decrementar,
    output logic                esCero
);

    logic [anchoCnt-1:0] cuenta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= valor;
        end else if (decrementar) begin
            cuenta <= cuenta - anchoCnt'(1);
        end
    end

    assign esCero = (cuenta == '0);

endmodule

// File: rtl/controlador_alu.sv
// Sequencing controller: accepts a request, drives the mux select for the
// operation's latency, then captures and strobes the result with flags.
module controlador_alu
    import alu_pkg::*;
#(
    parameter int ancho       = 3,
    parameter int latenciaDiv = 4
) (
    input logic              clk,
    input logic              rst,
    controlador_alu_if.slave bus
);

    localparam int ANCHO_CNT = $clog2(latenciaDiv) + 1;

    estado_t              estado;
    logic [3:0]           seleccionQ;
    logic [ancho:0]       salidaAQ;
    logic [ancho:0]       salidaBQ;
    logic [ancho:0]       resultadoQ;
    logic                 ceroQ;
    logic                 negativoQ;
    logic                 errorQ;
    logic                 valida;
    logic                 esDivision;
    logic                 carga;
    logic                 cntCero;
    logic [ANCHO_CNT-1:0] valorCarga;

    assign valida     = esValida(bus.operacion, 32'(bus.operandoB));
    assign esDivision = (bus.operacion == OP_DIV) || (bus.operacion == OP_MOD);
    assign valorCarga = esDivision ? ANCHO_CNT'(latenciaDiv - 1) : '0;
    assign carga      = (estado == ESPERA) && bus.inicio && valida;

    contador_latencia #(.anchoCnt(ANCHO_CNT)) uContador (
        .clk         (clk),
        .rst         (rst),
        .cargar      (carga),
        .valor       (valorCarga),
        .decrementar ((estado == EJECUTA) && !cntCero),
        .esCero      (cntCero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= ESPERA;
            seleccionQ <= '0;
            salidaAQ   <= '0;
            salidaBQ   <= '0;
            resultadoQ <= '0;
            ceroQ      <= 1'b0;
            negativoQ  <= 1'b0;
            errorQ     <= 1'b0;
        end else begin
            case (estado)
                ESPERA: begin
                    if (bus.inicio) begin
                        if (valida) begin
                            seleccionQ <= bus.operacion;
                            salidaAQ   <= bus.operandoA;
                            salidaBQ   <= bus.operandoB;
                            errorQ     <= 1'b0;
                            estado     <= EJECUTA;
                        end else begin
                            // Rejected: outputs toward the datapath stay as they were.
                            errorQ     <= 1'b1;
                            resultadoQ <= '0;
                            ceroQ      <= 1'b0;
                            negativoQ  <= 1'b0;
                            estado     <= ENTREGA;
                        end
                    end
                end
                EJECUTA: begin
                    if (cntCero) begin
                        resultadoQ <= bus.resultadoMux;
                        ceroQ      <= (bus.resultadoMux == '0);
                        negativoQ  <= bus.resultadoMux[ancho];
                        estado     <= ENTREGA;
                    end
                end
                ENTREGA: estado <= ESPERA;
                default: estado <= ESPERA;
            endcase
        end
    end

    assign bus.listo     = (estado == ESPERA);
    assign bus.valido    = (estado == ENTREGA);
    assign bus.estado    = estado;
    assign bus.seleccion = seleccionQ;
    assign bus.salidaA   = salidaAQ;
    assign bus.salidaB   = salidaBQ;
    assign bus.resultado = resultadoQ;
    assign bus.cero      = ceroQ;
    assign bus.negativo  = negativoQ;
    assign bus.error     = errorQ;

endmodule

// File: tb/tb_controlador_alu.sv
// Directed bench for controlador_alu with a behavioural model of the ALU mux.
module tb_controlador_alu;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   pulses;

  controlador_alu_if #(.ancho(3)) bus ();

  controlador_alu #(.ancho(3), .latenciaDiv(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model feeding the result multiplexer input
  function automatic logic [3:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return (b != 0) ? a / b : 4'd0;
      4'd4: return (b != 0) ? a % b : 4'd0;
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      4'd8: return a << b;
      4'd9: return a >> b;
      default: return 4'd0;
    endcase
  endfunction

  always_comb bus.resultadoMux = alu_model(bus.seleccion, bus.salidaA, bus.salidaB);

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    bus.inicio    = 1'b1;
    bus.operandoA = a;
    bus.operandoB = b;
    bus.operacion = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.inicio = 1'b0; bus.operandoA = '0; bus.operandoB = '0; bus.operacion = '0;
    repeat (2) tick();
    tests_run++; if (bus.listo !== 1'b1) begin tests_failed++; $display("FAIL reset_listo: got %b expected 1", bus.listo); end
    tests_run++; if (bus.valido !== 1'b0) begin tests_failed++; $display("FAIL reset_valido: got %b expected 0", bus.valido); end
    tests_run++; if (bus.resultado !== 4'd0) begin tests_failed++; $display("FAIL reset_resultado: got %0d expected 0", bus.resultado); end
    tests_run++; if (bus.seleccion !== 4'd0) begin tests_failed++; $display("FAIL reset_seleccion: got %0d expected 0", bus.seleccion); end
    tests_run++; if ({bus.error, bus.cero, bus.negativo} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {bus.error, bus.cero, bus.negativo}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_suma();
    drive_req(4'd3, 4'd5, OP_SUMA);
    tick(); // edge k
    bus.inicio = 1'b0;
    tests_run++; if (bus.listo !== 1'b0) begin tests_failed++; $display("FAIL suma_listo_k: got %b expected 0", bus.listo); end
    tests_run++; if (bus.valido !== 1'b0) begin tests_failed++; $display("FAIL suma_valido_k: got %b expected 0", bus.valido); end
    tests_run++; if ({bus.salidaA, bus.salidaB} !== {4'd3, 4'd5}) begin tests_failed++; $display("FAIL suma_operandos: got %h expected 35", {bus.salidaA, bus.salidaB}); end
    tick(); // edge k+1
    tests_run++; if (bus.valido !== 1'b1) begin tests_failed++; $display("FAIL suma_valido: got %b expected 1", bus.valido); end
    tests_run++; if (bus.resultado !== 4'd8) begin tests_failed++; $display("FAIL suma_resultado: got %0d expected 8", bus.resultado); end
    tests_run++; if ({bus.error, bus.cero, bus.negativo} !== 3'b001) begin tests_failed++; $display("FAIL suma_flags: got %b expected 001", {bus.error, bus.cero, bus.negativo}); end
    tests_run++; if (bus.listo !== 1'b0) begin tests_failed++; $display("FAIL suma_listo_k1: got %b expected 0", bus.listo); end
    tick(); // edge k+2
    tests_run++; if ({bus.listo, bus.valido} !== 2'b10) begin tests_failed++; $display("FAIL suma_fin: got listo,valido=%b expected 10", {bus.listo, bus.valido}); end
    tests_run++; if (bus.resultado !== 4'd8) begin tests_failed++; $display("FAIL suma_hold: got %0d expected 8", bus.resultado); end
  endtask

  task automatic test_division();
    pulses = 0;
    drive_req(4'd9, 4'd2, OP_DIV); // inicio stays high until after the result
    for (int c = 0; c < 4; c++) begin
      tick(); // edges k .. k+3
      if (bus.valido) pulses++;
      tests_run++; if ({bus.seleccion, bus.valido, bus.listo} !== {4'd3, 2'b00}) begin
        tests_failed++; $display("FAIL div_ejecuta_%0d: got sel=%0d valido=%b listo=%b expected 3,0,0", c, bus.seleccion, bus.valido, bus.listo);
      end
    end
    tick(); // edge k+4
    if (bus.valido) pulses++;
    tests_run++; if (bus.valido !== 1'b1) begin tests_failed++; $display("FAIL div_valido: got %b expected 1", bus.valido); end
    tests_run++; if ({bus.resultado, bus.error, bus.negativo} !== {4'd4, 2'b00}) begin tests_failed++; $display("FAIL div_resultado: got res=%0d err=%b neg=%b expected 4,0,0", bus.resultado, bus.error, bus.negativo); end
    tick(); // edge k+5
    if (bus.valido) pulses++;
    bus.inicio = 1'b0;
    tests_run++; if (bus.listo !== 1'b1) begin tests_failed++; $display("FAIL div_listo: got %b expected 1", bus.listo); end
    repeat (3) begin tick(); if (bus.valido) pulses++; end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL div_pulsos: got %0d expected 1", pulses); end
  endtask

  task automatic test_rechazo();
    logic [3:0] ops [2];
    logic [3:0] bs  [2];
    ops[0] = OP_MOD; bs[0] = 4'd0;
    ops[1] = 4'd12;  bs[1] = 4'd1;
    for (int i = 0; i < 2; i++) begin
      drive_req(4'd7, bs[i], ops[i]);
      tick(); // edge k
      bus.inicio = 1'b0;
      tests_run++; if ({bus.valido, bus.error, bus.listo} !== 3'b110) begin tests_failed++; $display("FAIL rechazo%0d_handshake: got valido,error,listo=%b expected 110", i, {bus.valido, bus.error, bus.listo}); end
      tests_run++; if ({bus.resultado, bus.cero, bus.negativo} !== 6'd0) begin tests_failed++; $display("FAIL rechazo%0d_resultado: got res=%0d cero=%b neg=%b expected 0,0,0", i, bus.resultado, bus.cero, bus.negativo); end
      tests_run++; if ({bus.seleccion, bus.salidaA, bus.salidaB} !== {4'd3, 4'd9, 4'd2}) begin tests_failed++; $display("FAIL rechazo%0d_sin_carga: got %h expected 392", i, {bus.seleccion, bus.salidaA, bus.salidaB}); end
      tick(); // edge k+1
      tests_run++; if ({bus.listo, bus.valido} !== 2'b10) begin tests_failed++; $display("FAIL rechazo%0d_fin: got listo,valido=%b expected 10", i, {bus.listo, bus.valido}); end
    end
  endtask

  task automatic test_xor_cero();
    drive_req(4'd6, 4'd6, OP_XOR);
    tick();
    bus.inicio = 1'b0;
    tick();
    tests_run++; if (bus.valido !== 1'b1) begin tests_failed++; $display("FAIL xor_valido: got %b expected 1", bus.valido); end
    tests_run++; if ({bus.resultado, bus.error, bus.cero, bus.negativo} !== {4'd0, 3'b010}) begin tests_failed++; $display("FAIL xor_resultado: got res=%0d err=%b cero=%b neg=%b expected 0,0,1,0", bus.resultado, bus.error, bus.cero, bus.negativo); end
    tick();
  endtask

  task automatic test_modulo();
    drive_req(4'd7, 4'd3, OP_MOD);
    tick(); // edge k
    bus.inicio = 1'b0;
    repeat (3) tick();
    tests_run++; if (bus.valido !== 1'b0) begin tests_failed++; $display("FAIL mod_temprano: got %b expected 0", bus.valido); end
    tick(); // edge k+4
    tests_run++; if ({bus.valido, bus.resultado} !== {1'b1, 4'd1}) begin tests_failed++; $display("FAIL mod_resultado: got valido=%b res=%0d expected 1,1", bus.valido, bus.resultado); end
    tick();
  endtask

  task automatic test_reset_medio();
    pulses = 0;
    drive_req(4'd9, 4'd2, OP_DIV);
    tick(); // edge k
    bus.inicio = 1'b0;
    repeat (2) tick(); // k+2
    rst = 1'b1;
    #1;
    tests_run++; if ({bus.listo, bus.valido} !== 2'b10) begin tests_failed++; $display("FAIL rstmed_inmediato: got listo,valido=%b expected 10", {bus.listo, bus.valido}); end
    tests_run++; if ({bus.seleccion, bus.salidaA, bus.resultado} !== 12'd0) begin tests_failed++; $display("FAIL rstmed_valores: got %h expected 000", {bus.seleccion, bus.salidaA, bus.resultado}); end
    tick();
    rst = 1'b0;
    repeat (6) begin tick(); if (bus.valido) pulses++; end
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL rstmed_sin_pulso: got %0d expected 0", pulses); end
    drive_req(4'd1, 4'd1, OP_SUMA);
    tick();
    bus.inicio = 1'b0;
    tick();
    tests_run++; if ({bus.valido, bus.resultado, bus.cero, bus.negativo} !== {1'b1, 4'd2, 2'b00}) begin tests_failed++; $display("FAIL rstmed_suma: got valido=%b res=%0d cero=%b neg=%b expected 1,2,0,0", bus.valido, bus.resultado, bus.cero, bus.negativo); end
    tick();
  endtask

  task automatic test_shift();
    drive_req(4'd3, 4'd2, OP_SHIFT_IZQ);
    tick();
    bus.inicio = 1'b0;
    tests_run++; if (bus.seleccion !== 4'd8) begin tests_failed++; $display("FAIL shift_seleccion: got %0d expected 8", bus.seleccion); end
    tick();
    tests_run++; if ({bus.valido, bus.resultado, bus.negativo} !== {1'b1, 4'd12, 1'b1}) begin tests_failed++; $display("FAIL shift_resultado: got valido=%b res=%0d neg=%b expected 1,12,1", bus.valido, bus.resultado, bus.negativo); end
    tick();
  endtask

  // sequence and final report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_suma();
    test_division();
    test_rechazo();
    test_xor_cero();
    test_modulo();
    test_reset_medio();
    test_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
